// File: rtl/instr_assembler.sv
// RV32I instruction assembler: packs I/S/B/J fields into a word and streams it into instruction memory.
// Optional IMM_RANGE_CHECK_EN drops writes for out-of-range immediates and raises a sticky Err.
module instr_assembler #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Start,
  input  logic [AW-1:0] BaseAddr,
  input  logic          InValid,
  output logic          InReady,
  input  logic          InLast,
  input  logic [1:0]    ImmSrc,
  input  logic [6:0]    Op,
  input  logic [4:0]    Rd,
  input  logic [4:0]    Rs1,
  input  logic [4:0]    Rs2,
  input  logic [2:0]    Funct3,
  input  logic [31:0]   Imm,
  output logic          IMemWE,
  output logic [AW-1:0] IMemAddr,
  output logic [31:0]   IMemWD,
  output logic          Done,
  output logic          Full,
  output logic          Err,
  output logic          dbgState
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } stateT;

  localparam logic [1:0] SRC_I = 2'b00;
  localparam logic [1:0] SRC_S = 2'b01;
  localparam logic [1:0] SRC_B = 2'b10;
  localparam logic [1:0] SRC_J = 2'b11;

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  stateT         state;
  logic [AW-1:0] addrCnt;
  logic [31:0]   encWord;
  logic          accept;
  logic          writeOk;

  // Handshake: a bundle transfers on a cycle where InValid && InReady at the rising edge;
  // InValid may be held or dropped freely, InReady never depends on InValid.
  assign InReady  = (state == RUN) && !Full;
  assign accept   = InValid && InReady;
  assign dbgState = state;

  always_comb begin
    encWord = '0;
    case (ImmSrc)
      SRC_I: encWord = {Imm[11:0], Rs1, Funct3, Rd, Op};
      SRC_S: encWord = {Imm[11:5], Rs2, Rs1, Funct3, Imm[4:0], Op};
      SRC_B: encWord = {Imm[12], Imm[10:5], Rs2, Rs1, Funct3, Imm[4:1], Imm[11], Op};
      SRC_J: encWord = {Imm[20], Imm[10:1], Imm[11], Imm[19:12], Rd, Op};
      default: encWord = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // An immediate fits when every bit above the field's sign bit copies it; B/J must be even.
  always_comb begin
    writeOk = 1'b1;
    case (ImmSrc)
      SRC_I, SRC_S: writeOk = (Imm[31:11] == {21{Imm[11]}});
      SRC_B:        writeOk = (Imm[31:12] == {20{Imm[12]}}) && !Imm[0];
      SRC_J:        writeOk = (Imm[31:20] == {12{Imm[20]}}) && !Imm[0];
      default:      writeOk = 1'b1;
    endcase
  end
`else
  logic unusedImmBits;
  assign unusedImmBits = ^Imm[31:21];
  assign writeOk       = 1'b1;
  assign Err           = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      addrCnt  <= '0;
      IMemWE   <= 1'b0;
      IMemAddr <= '0;
      IMemWD   <= '0;
      Done     <= 1'b0;
      Full     <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
      Err      <= 1'b0;
`endif
    end else begin
      IMemWE <= 1'b0;
      Done   <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            state   <= RUN;
            addrCnt <= BaseAddr;
            Full    <= 1'b0;
`ifdef IMM_RANGE_CHECK_EN
            Err     <= 1'b0;
`endif
          end
        end
        RUN: begin
          if (accept) begin
            if (writeOk) begin
              IMemWE   <= 1'b1;
              IMemAddr <= addrCnt;
              IMemWD   <= encWord;
              // The last word pins the counter instead of wrapping onto the program start.
              if (addrCnt == LAST_ADDR) begin
                Full <= 1'b1;
              end else begin
                addrCnt <= addrCnt + 1'b1;
              end
            end
`ifdef IMM_RANGE_CHECK_EN
            if (!writeOk) begin
              Err <= 1'b1;
            end
`endif
            if (InLast) begin
              Done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler: hand-encoded RV32I words, range errors, address-end and reset cases.
module tb_instr_assembler;

  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic          Start;
  logic [AW-1:0] BaseAddr;
  logic          InValid;
  logic          InReady;
  logic          InLast;
  logic [1:0]    ImmSrc;
  logic [6:0]    Op;
  logic [4:0]    Rd;
  logic [4:0]    Rs1;
  logic [4:0]    Rs2;
  logic [2:0]    Funct3;
  logic [31:0]   Imm;
  logic          IMemWE;
  logic [AW-1:0] IMemAddr;
  logic [31:0]   IMemWD;
  logic          Done;
  logic          Full;
  logic          Err;
  logic          dbgState;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [AW+31:0] exp_q[$];

  instr_assembler #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .Start(Start), .BaseAddr(BaseAddr),
    .InValid(InValid), .InReady(InReady), .InLast(InLast), .ImmSrc(ImmSrc),
    .Op(Op), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2), .Funct3(Funct3), .Imm(Imm),
    .IMemWE(IMemWE), .IMemAddr(IMemAddr), .IMemWD(IMemWD),
    .Done(Done), .Full(Full), .Err(Err), .dbgState(dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [1:0] src, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [31:0] imm, input logic last);
    InValid = 1'b1;
    ImmSrc  = src;
    Op      = op;
    Rd      = rd;
    Rs1     = rs1;
    Rs2     = rs2;
    Funct3  = f3;
    Imm     = imm;
    InLast  = last;
  endtask

  task automatic idle_in();
    InValid = 1'b0;
    InLast  = 1'b0;
  endtask

  task automatic start_at(input logic [AW-1:0] base);
    Start    = 1'b1;
    BaseAddr = base;
    tick();
    Start    = 1'b0;
  endtask

  // scoreboard
  task automatic push_exp(input logic [AW-1:0] addr, input logic [31:0] wd);
    exp_q.push_back({addr, wd});
  endtask

  task automatic expect_write(input string tag);
    logic [AW+31:0] item;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      item = exp_q.pop_front();
      chk({tag, "_we"}, 32'(IMemWE), 32'd1);
      chk({tag, "_addr"}, 32'(IMemAddr), 32'(item[AW+31:32]));
      chk({tag, "_wd"}, IMemWD, item[31:0]);
    end
  endtask

  initial begin
    reset    = 1'b0;
    Start    = 1'b0;
    BaseAddr = '0;
    InValid  = 1'b0;
    InLast   = 1'b0;
    ImmSrc   = 2'b00;
    Op       = '0;
    Rd       = '0;
    Rs1      = '0;
    Rs2      = '0;
    Funct3   = '0;
    Imm      = '0;

    // reset state
    tick();
    tick();
    chk("rst_we", 32'(IMemWE), 32'd0);
    chk("rst_addr", 32'(IMemAddr), 32'd0);
    chk("rst_wd", IMemWD, 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_full", 32'(Full), 32'd0);
    chk("rst_err", 32'(Err), 32'd0);
    chk("rst_ready", 32'(InReady), 32'd0);
    chk("rst_state", 32'(dbgState), 32'd0);
    reset = 1'b1;
    tick();
    chk("idle_ready", 32'(InReady), 32'd0);

    // program of four words, one of each format
    start_at(8'h10);
    chk("run_ready", 32'(InReady), 32'd1);
    chk("run_state", 32'(dbgState), 32'd1);
    drive(2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd5, 1'b0);
    push_exp(8'h10, 32'h00500093);
    tick();
    expect_write("i_fmt");
    drive(2'b01, 7'b0100011, 5'd0, 5'd0, 5'd2, 3'b010, 32'd8, 1'b0);
    push_exp(8'h11, 32'h00202423);
    tick();
    expect_write("s_fmt");
    drive(2'b10, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, -32'sd4, 1'b0);
    push_exp(8'h12, 32'hFE000EE3);
    tick();
    expect_write("b_fmt");
    chk("b_done", 32'(Done), 32'd0);
    drive(2'b11, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 32'd8, 1'b1);
    push_exp(8'h13, 32'h008000EF);
    tick();
    expect_write("j_fmt");
    chk("j_done", 32'(Done), 32'd1);
    chk("j_ready", 32'(InReady), 32'd0);
    chk("j_state", 32'(dbgState), 32'd0);
    tick();
    chk("post_last_we", 32'(IMemWE), 32'd0);
    chk("post_last_done", 32'(Done), 32'd0);
    idle_in();

    // immediate range: 2048 does not fit I, 3 is odd for B
    start_at(8'h20);
    drive(2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2048, 1'b0);
`ifndef IMM_RANGE_CHECK_EN
    push_exp(8'h20, 32'h80000093);
`endif
    tick();
`ifdef IMM_RANGE_CHECK_EN
    chk("rng_i_we", 32'(IMemWE), 32'd0);
    chk("rng_i_err", 32'(Err), 32'd1);
`else
    expect_write("trunc_i");
    chk("trunc_i_err", 32'(Err), 32'd0);
`endif
    drive(2'b10, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'b000, 32'd3, 1'b0);
`ifndef IMM_RANGE_CHECK_EN
    push_exp(8'h21, 32'h00000163);
`endif
    tick();
`ifdef IMM_RANGE_CHECK_EN
    chk("rng_b_we", 32'(IMemWE), 32'd0);
    chk("rng_b_err", 32'(Err), 32'd1);
    push_exp(8'h20, 32'h00500093);
`else
    expect_write("trunc_b");
    push_exp(8'h22, 32'h00500093);
`endif
    drive(2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd5, 1'b1);
    tick();
    expect_write("after_rng");
    chk("after_rng_done", 32'(Done), 32'd1);
`ifdef IMM_RANGE_CHECK_EN
    chk("err_sticky", 32'(Err), 32'd1);
`endif
    idle_in();
    tick();

    // top of memory: two writes, Full with the second, third bundle refused
    start_at(8'hFE);
    chk("start_clr_err", 32'(Err), 32'd0);
    chk("start_full", 32'(Full), 32'd0);
    drive(2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd1, 1'b0);
    push_exp(8'hFE, 32'h00100093);
    tick();
    expect_write("top0");
    chk("top0_full", 32'(Full), 32'd0);
    chk("top0_ready", 32'(InReady), 32'd1);
    drive(2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd2, 1'b0);
    push_exp(8'hFF, 32'h00200093);
    tick();
    expect_write("top1");
    chk("top1_full", 32'(Full), 32'd1);
    chk("top1_ready", 32'(InReady), 32'd0);
    drive(2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd3, 1'b0);
    tick();
    chk("top2_we", 32'(IMemWE), 32'd0);
    chk("top2_addr", 32'(IMemAddr), 32'hFF);
    start_at(8'h00);
    chk("run_start_ignored_full", 32'(Full), 32'd1);
    chk("run_start_ignored_state", 32'(dbgState), 32'd1);
    chk("run_start_ignored_we", 32'(IMemWE), 32'd0);
    idle_in();

    // reset while a second accepted bundle is pending
    reset = 1'b0;
    tick();
    reset = 1'b1;
    start_at(8'h30);
    drive(2'b00, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 32'd5, 1'b0);
    push_exp(8'h30, 32'h00500093);
    tick();
    expect_write("pre_rst");
    drive(2'b01, 7'b0100011, 5'd0, 5'd0, 5'd2, 3'b010, 32'd8, 1'b0);
    reset = 1'b0;
    tick();
    chk("mid_rst_we", 32'(IMemWE), 32'd0);
    chk("mid_rst_addr", 32'(IMemAddr), 32'd0);
    chk("mid_rst_wd", IMemWD, 32'd0);
    chk("mid_rst_done", 32'(Done), 32'd0);
    chk("mid_rst_full", 32'(Full), 32'd0);
    chk("mid_rst_ready", 32'(InReady), 32'd0);
    chk("mid_rst_state", 32'(dbgState), 32'd0);
    reset = 1'b1;
    idle_in();
    tick();
    chk("mid_rst_after_we", 32'(IMemWE), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
